top_memory_test: RTL and testbench



---
 rtl/top_memory_test.sv | 187 ++++++++++++++++++
 tb/tb_top_memory_test.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/top_memory_test.sv
// Self-contained DCT test top: a preloaded 512-word image memory streamed one
// word per clock into a 16-point 1-D DCT with 11-bit truncated coefficients.

module tmt_mem #(
  parameter int DEPTH = 512,
  parameter int W     = 128,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  output logic [W-1:0]  dout_o
);
  // Contents are loaded from outside the design; no reset, no write port.
  logic [W-1:0] array [DEPTH];

  always_ff @(posedge clk) dout_o <= array[addr_i];
endmodule

module tmt_dct_col #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 11,
  parameter int CF_W  = 13,
  parameter int ACC_W = 25
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_vld_i,
  input  logic [16*PIX_W-1:0]   word_i,
  output logic [16*OUT_W-1:0]   coef_o
);
  function automatic int cos_tab(input int m);
    case (m)
      0: return 1448;   1: return 1441;   2: return 1420;   3: return 1386;
      4: return 1338;   5: return 1277;   6: return 1204;   7: return 1119;
      8: return 1024;   9: return 919;   10: return 805;   11: return 683;
      12: return 554;  13: return 420;   14: return 283;   15: return 142;
      default: return 0;
    endcase
  endfunction

  // Fold the cosine argument (2n+1)k*pi/32 into the first quadrant table.
  function automatic int cf(input int k, input int n);
    int m;
    if (k == 0) return 1024;
    m = ((2*n + 1) * k) % 64;
    if (m > 32) m = 64 - m;
    if (m <= 16) return cos_tab(m);
    return -cos_tab(32 - m);
  endfunction

  logic [15:0][OUT_W-1:0] xk_d;

  for (genvar k = 0; k < 16; k++) begin : g_k
    logic signed [ACC_W-1:0] prod [8];
    logic signed [ACC_W-1:0] acc;
    logic                    unused_acc;

    // C[k][15-n] = (-1)^k C[k][n]: even rows use x_n+x_15-n, odd rows the difference.
    for (genvar n = 0; n < 8; n++) begin : g_n
      localparam logic signed [CF_W-1:0] C = CF_W'(cf(k, n));
      logic [PIX_W-1:0]        xa, xb;
      logic signed [PIX_W+1:0] t;
      assign xa = word_i[n*PIX_W +: PIX_W];
      assign xb = word_i[(15-n)*PIX_W +: PIX_W];
      if (k % 2 == 0) begin : g_even
        assign t = $signed({2'b00, xa}) + $signed({2'b00, xb});
      end else begin : g_odd
        assign t = $signed({2'b00, xa}) - $signed({2'b00, xb});
      end
      assign prod[n] = ACC_W'(t) * ACC_W'(C);
    end

    always_comb begin
      acc = '0;
      for (int n = 0; n < 8; n++) acc = acc + prod[n];
    end

    assign xk_d[k]    = acc[12 +: OUT_W];
    assign unused_acc = ^{acc[11:0], acc[ACC_W-1:12+OUT_W]};
  end

  logic [OUT_W-1:0] X_0_trunc,  X_1_trunc,  X_2_trunc,  X_3_trunc;
  logic [OUT_W-1:0] X_4_trunc,  X_5_trunc,  X_6_trunc,  X_7_trunc;
  logic [OUT_W-1:0] X_8_trunc,  X_9_trunc,  X_10_trunc, X_11_trunc;
  logic [OUT_W-1:0] X_12_trunc, X_13_trunc, X_14_trunc, X_15_trunc;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      X_0_trunc  <= '0;  X_1_trunc  <= '0;  X_2_trunc  <= '0;  X_3_trunc  <= '0;
      X_4_trunc  <= '0;  X_5_trunc  <= '0;  X_6_trunc  <= '0;  X_7_trunc  <= '0;
      X_8_trunc  <= '0;  X_9_trunc  <= '0;  X_10_trunc <= '0;  X_11_trunc <= '0;
      X_12_trunc <= '0;  X_13_trunc <= '0;  X_14_trunc <= '0;  X_15_trunc <= '0;
    end else if (in_vld_i) begin
      X_0_trunc  <= xk_d[0];   X_1_trunc  <= xk_d[1];
      X_2_trunc  <= xk_d[2];   X_3_trunc  <= xk_d[3];
      X_4_trunc  <= xk_d[4];   X_5_trunc  <= xk_d[5];
      X_6_trunc  <= xk_d[6];   X_7_trunc  <= xk_d[7];
      X_8_trunc  <= xk_d[8];   X_9_trunc  <= xk_d[9];
      X_10_trunc <= xk_d[10];  X_11_trunc <= xk_d[11];
      X_12_trunc <= xk_d[12];  X_13_trunc <= xk_d[13];
      X_14_trunc <= xk_d[14];  X_15_trunc <= xk_d[15];
    end
  end

  assign coef_o = {X_15_trunc, X_14_trunc, X_13_trunc, X_12_trunc,
                   X_11_trunc, X_10_trunc, X_9_trunc,  X_8_trunc,
                   X_7_trunc,  X_6_trunc,  X_5_trunc,  X_4_trunc,
                   X_3_trunc,  X_2_trunc,  X_1_trunc,  X_0_trunc};
endmodule

module tmt_dct #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 11,
  parameter int CF_W  = 13
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_vld_i,
  input  logic [16*PIX_W-1:0] word_i,
  output logic [16*OUT_W-1:0] coef_o
);
  tmt_dct_col #(.PIX_W(PIX_W), .OUT_W(OUT_W), .CF_W(CF_W)) DCT_col (
    .clk      (clk),
    .rstn     (rstn),
    .in_vld_i (in_vld_i),
    .word_i   (word_i),
    .coef_o   (coef_o)
  );
endmodule

module top_memory_test #(
  parameter int DEPTH = 512,
  parameter int PIX_W = 8,
  parameter int OUT_W = 11,
  parameter int CF_W  = 13
) (
  input  logic                clk,
  input  logic                rstn,
  output logic [16*OUT_W-1:0] dct_out,
  output logic                out_valid,
  output logic                done
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic                en_q, last_q, done_q;
  logic [AW-1:0]       addr_q;
  logic [1:0]          vld_pipe_q;   // [0] mem dout valid, [1] coefficients valid
  logic                rd_vld;
  logic [16*PIX_W-1:0] word;

  // en_q delays the first increment so address a is presented during cycle a.
  assign rd_vld = en_q & ~last_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      en_q       <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      en_q       <= 1'b1;
      vld_pipe_q <= {vld_pipe_q[0], rd_vld};
      if (rd_vld && addr_q != LAST) addr_q <= addr_q + AW'(1);
      if (rd_vld && addr_q == LAST) last_q <= 1'b1;
      if (last_q && vld_pipe_q[1] && !vld_pipe_q[0]) done_q <= 1'b1;
    end
  end

  tmt_mem #(.DEPTH(DEPTH), .W(16*PIX_W), .AW(AW)) MEM_IN (
    .clk    (clk),
    .addr_i (addr_q),
    .dout_o (word)
  );

  tmt_dct #(.PIX_W(PIX_W), .OUT_W(OUT_W), .CF_W(CF_W)) DCT (
    .clk      (clk),
    .rstn     (rstn),
    .in_vld_i (vld_pipe_q[0]),
    .word_i   (word),
    .coef_o   (dct_out)
  );

  assign out_valid = vld_pipe_q[1];
  assign done      = done_q;
endmodule

// File: tb/tb_top_memory_test.sv
// Directed bench for top_memory_test: hand-computed vectors, a real-valued
// golden DCT model, run timing, mid-run reset and post-run hold.

module tb_top_memory_test;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [175:0] dct_out;
  logic         out_valid, done;

  top_memory_test dut (
    .clk       (clk),
    .rstn      (rstn),
    .dct_out   (dct_out),
    .out_valid (out_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] word;
    int           exp [16];
  } vec_t;

  int           errs = 0, checks = 0;
  int           ctab [16][16];
  logic [127:0] img  [512];
  vec_t         vt   [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [175:0] act, input logic [175:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [175:0] gold(input logic [127:0] w);
    logic [175:0] r;
    longint       acc;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      acc = 0;
      for (int n = 0; n < 16; n++) acc += longint'(w[8*n +: 8]) * ctab[k][n];
      r[11*k +: 11] = 11'(acc >>> 12);
    end
    return r;
  endfunction

  function automatic logic [175:0] pack(input int e [16]);
    logic [175:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[11*k +: 11] = 11'(e[k]);
    return r;
  endfunction

  task automatic load_img();
    for (int i = 0; i < 512; i++) dut.MEM_IN.array[i] = img[i];
  endtask

  initial begin
    real pi, a, v;
    pi = 3.14159265358979;
    for (int k = 0; k < 16; k++)
      for (int n = 0; n < 16; n++) begin
        a = (k == 0) ? 0.25 : $sqrt(2.0) / 4.0;
        v = 4096.0 * a * $cos(pi * real'((2*n + 1) * k) / 32.0);
        ctab[k][n] = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
      end

    vt[0].word = {16{8'hFF}};
    vt[0].exp  = '{1020, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1].word = 128'd100;
    vt[1].exp  = '{25, 35, 34, 33, 32, 31, 29, 27, 25, 22, 19, 16, 13, 10, 6, 3};
    vt[2].word = {8'd100, 120'd0};
    vt[2].exp  = '{25, -36, 34, -34, 32, -32, 29, -28, 25, -23, 19, -17, 13, -11, 6, -4};
    vt[3].word = '0;
    vt[3].exp  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 512; i++) img[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) img[i] = vt[i].word;
    load_img();

    // Reset state
    rstn = 1'b0;
    step(); step();
    chk("reset out_valid", out_valid, 0);
    chk("reset done", done, 0);
    chk("reset dct_out", dct_out, 0);

    // Run A: table vectors then random words, followed by a long hold
    rstn = 1'b1;
    for (int c = 0; c <= 1513; c++) begin
      step();
      chk($sformatf("A valid c%0d", c), out_valid, (c >= 2 && c <= 513));
      chk($sformatf("A done c%0d", c), done, (c >= 514));
      if (c >= 2 && c <= 5) chk($sformatf("table vec%0d", c - 2), dct_out, pack(vt[c-2].exp));
      if (c == 2) chk("X_0_trunc probe", dut.DCT.DCT_col.X_0_trunc, 176'd1020);
      if (c >= 2 && c <= 513) chk($sformatf("A dct c%0d", c), dct_out, gold(img[c-2]));
      if (c >= 514) begin
        chk($sformatf("hold dct c%0d", c), dct_out, gold(img[511]));
        chk($sformatf("hold addr c%0d", c), dut.addr_q, 511);
      end
    end

    // Run B: all-zero memory
    rstn = 1'b0;
    for (int i = 0; i < 512; i++) dut.MEM_IN.array[i] = '0;
    step();
    chk("B reset dct_out", dct_out, 0);
    chk("B reset done", done, 0);
    rstn = 1'b1;
    for (int c = 0; c <= 515; c++) begin
      step();
      chk($sformatf("B valid c%0d", c), out_valid, (c >= 2 && c <= 513));
      chk($sformatf("B done c%0d", c), done, (c >= 514));
      chk($sformatf("B dct c%0d", c), dct_out, 0);
    end

    // Run C: reset pulse at cycle 200, then a clean restart
    load_img();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int c = 0; c < 200; c++) step();
    chk("C pre-reset valid", out_valid, 1);
    rstn = 1'b0;
    step();
    chk("C mid-reset valid", out_valid, 0);
    chk("C mid-reset dct", dct_out, 0);
    chk("C mid-reset done", done, 0);
    chk("C mid-reset addr", dut.addr_q, 0);
    rstn = 1'b1;
    for (int c = 0; c <= 514; c++) begin
      step();
      chk($sformatf("C valid c%0d", c), out_valid, (c >= 2 && c <= 513));
      chk($sformatf("C done c%0d", c), done, (c >= 514));
      if (c < 2) chk($sformatf("C dct zero c%0d", c), dct_out, 0);
      if (c >= 2 && c <= 513) chk($sformatf("C dct c%0d", c), dct_out, gold(img[c-2]));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
